tug_of_war_field: RTL
=====================

Name: tug_of_war_field

Overview:
- Parametrised playfield controller for the Tug of War game.
- Replaces a chain of per-position single-light cells with one block that owns N lights, round scoring, an inter-round pause and match-over detection.
- Sits between the debounced, edge-detected player button pulses and the LED and score display drivers.

Parameters:
- NUM_LIGHTS, 9, number of field lights; must be odd and >= 3. CENTER = (NUM_LIGHTS-1)/2.
- WIN_SCORE, 7, rounds a player must win to take the match; must be >= 1.
- HOLD_CYCLES, 50000000, clock cycles the field stays dark after a round win; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset asserted.
- leftPress  in  1  single-cycle pulse; left player pulls.
- rightPress  in  1  single-cycle pulse; right player pulls.
- newMatch  in  1  single-cycle pulse; restarts the match.
- lights  out  NUM_LIGHTS  field LEDs. Bit NUM_LIGHTS-1 is leftmost; bit 0 is rightmost.
- leftScore  out  $clog2(WIN_SCORE+1)  rounds won by left player.
- rightScore  out  $clog2(WIN_SCORE+1)  rounds won by right player.
- roundWin  out  1  one-cycle pulse when either player wins a round.
- roundWinnerLeft  out  1  1 = left player won the last round. Valid from the roundWin cycle onward; held.
- matchOver  out  1  high while the match has been decided.
- matchWinnerLeft  out  1  1 = left player won the match. Meaningful only while matchOver = 1.

Behaviour:
- Reset (reset == 0 at clk edge) values:
  - lights = one-hot at CENTER.
  - leftScore = rightScore = 0.
  - roundWin = roundWinnerLeft = matchOver = matchWinnerLeft = 0.
  - state = PLAY; hold counter = 0.
- Priority at each edge: reset, then newMatch, then state logic.
- newMatch applies the same values as reset on the next edge, in any state.
- Position pos is held internally, range 0..NUM_LIGHTS-1. In PLAY, lights = one-hot(pos). All outputs are registered; lights change on the edge that samples a press (1-cycle latency).
- State PLAY:
  - leftPress only: pos+1.
  - rightPress only: pos-1.
  - Both presses, or neither: no change. Simultaneous pulls cancel.
  - leftPress only with pos == NUM_LIGHTS-1 (left round win):
    - lights <= 0, leftScore +1, roundWin <= 1 for one cycle, roundWinnerLeft <= 1, pos <= CENTER.
    - If the new leftScore == WIN_SCORE: go to MATCH_OVER with matchOver <= 1 and matchWinnerLeft <= 1.
    - Otherwise: go to ROUND_END with hold counter <= HOLD_CYCLES-1.
  - rightPress only with pos == 0: mirror image of the left round win (rightScore increments, roundWinnerLeft <= 0, matchWinnerLeft <= 0).
- State ROUND_END:
  - lights = 0; all presses ignored.
  - Counter decrements each edge. On the edge where the counter == 0: go to PLAY with lights = one-hot(CENTER).
  - A round won at edge k therefore relights CENTER at edge k+HOLD_CYCLES.
- State MATCH_OVER:
  - lights = 0; presses ignored; scores frozen; matchOver held at 1.
  - Left only by reset or newMatch.
- Scores never exceed WIN_SCORE and never wrap.
- roundWin is never high for two consecutive cycles.
- Reset or newMatch mid-ROUND_END cancels the pause immediately.

Test Plan (bench parameters: NUM_LIGHTS=5, WIN_SCORE=2, HOLD_CYCLES=3):
- Reset held low 2 cycles, then released -> lights=5'b00100, both scores 0, matchOver=0.
- Single leftPress, then single rightPress, then leftPress and rightPress in the same cycle -> lights go 00100 -> 01000 -> 00100 -> 00100 (unchanged).
- Three leftPress pulses from centre ->
  - After the 2nd: lights=10000.
  - After the 3rd: lights=00000, roundWin=1 for exactly one cycle, leftScore=1, roundWinnerLeft=1.
  - 3 edges later: lights=00100.
- Presses during the ROUND_END pause -> ignored; lights stay 00000 and CENTER returns on schedule.
- Right player wins two rounds -> rightScore=2, matchOver=1, matchWinnerLeft=0, lights stay 00000; further presses cause no change.
- newMatch during MATCH_OVER, and reset driven low mid-ROUND_END -> next edge: lights=00100, scores 0, matchOver=0.

Source files
------------

// File: rtl/tug_of_war_field.sv
// -----------------------------------------------------------------------------
// tug_of_war_field
//
// Playfield controller for the Tug of War game. One block owns the row of
// field lights, the per-player round scores, the dark pause that follows a
// round win and the match-over condition. It sits between the debounced,
// edge-detected player button pulses and the LED / score display drivers.
//
// The rope position is an index 0..NUM_LIGHTS-1 (bit NUM_LIGHTS-1 of the
// light vector is the leftmost LED). A left pull moves it towards the left
// end and a right pull towards the right end. Pulling past an end wins the
// round for that player.
//
// Parameters:
//   NUM_LIGHTS  - number of field lights, odd and >= 3
//   WIN_SCORE   - rounds needed to take the match, >= 1
//   HOLD_CYCLES - clock cycles the field stays dark after a round win, >= 1
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous reset, active low (0 = reset)
//   leftPress       in   one-cycle pulse, left player pulls
//   rightPress      in   one-cycle pulse, right player pulls
//   newMatch        in   one-cycle pulse, restarts the match
//   lights          out  field LEDs, one-hot while playing, dark otherwise
//   leftScore       out  rounds won by the left player
//   rightScore      out  rounds won by the right player
//   roundWin        out  one-cycle pulse when a round is won
//   roundWinnerLeft out  1 = left won the last round, held until next win
//   matchOver       out  high once the match is decided
//   matchWinnerLeft out  1 = left won the match (valid while matchOver = 1)
// -----------------------------------------------------------------------------
module tug_of_war_field #(
   parameter int unsigned NUM_LIGHTS  = 9,
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned HOLD_CYCLES = 50000000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             leftPress,
   input  logic                             rightPress,
   input  logic                             newMatch,
   output logic [NUM_LIGHTS-1:0]            lights,
   output logic [$clog2(WIN_SCORE+1)-1:0]   leftScore,
   output logic [$clog2(WIN_SCORE+1)-1:0]   rightScore,
   output logic                             roundWin,
   output logic                             roundWinnerLeft,
   output logic                             matchOver,
   output logic                             matchWinnerLeft
);

   // --------------------------------------------------------------------------
   // Derived constants
   // --------------------------------------------------------------------------
   localparam int unsigned SCORE_W = $clog2(WIN_SCORE + 1);
   localparam int unsigned POS_W   = $clog2(NUM_LIGHTS);
   localparam int unsigned CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned CENTER  = (NUM_LIGHTS - 1) / 2;

   localparam logic [POS_W-1:0]      POS_LEFT   = POS_W'(NUM_LIGHTS - 1);
   localparam logic [POS_W-1:0]      POS_RIGHT  = '0;
   localparam logic [POS_W-1:0]      POS_CENTER = POS_W'(CENTER);
   localparam logic [SCORE_W-1:0]    SCORE_WIN  = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]      HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [NUM_LIGHTS-1:0] LIGHT_CTR  = NUM_LIGHTS'(1) << CENTER;

   // --------------------------------------------------------------------------
   // Parameter legality, reported at elaboration
   // --------------------------------------------------------------------------
   if ((NUM_LIGHTS < 3) || ((NUM_LIGHTS % 2) == 0)) begin : g_bad_num_lights
      $error("tug_of_war_field: NUM_LIGHTS must be odd and >= 3");
   end
   if (WIN_SCORE < 1) begin : g_bad_win_score
      $error("tug_of_war_field: WIN_SCORE must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
      $error("tug_of_war_field: HOLD_CYCLES must be >= 1");
   end

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_PLAY       = 2'd0,
      ST_ROUND_END  = 2'd1,
      ST_MATCH_OVER = 2'd2
   } state_e;

   state_e                 state_q;
   logic [POS_W-1:0]       pos_q;
   logic [CNT_W-1:0]       hold_q;
   logic [NUM_LIGHTS-1:0]  lights_q;
   logic [SCORE_W-1:0]     left_score_q;
   logic [SCORE_W-1:0]     right_score_q;
   logic                   round_win_q;
   logic                   round_winner_left_q;
   logic                   match_over_q;
   logic                   match_winner_left_q;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   // Simultaneous pulls cancel, so only a lone press moves the rope.
   logic                   pull_left;
   logic                   pull_right;
   logic                   left_wins_round;
   logic                   right_wins_round;
   logic [POS_W-1:0]       pos_left_d;
   logic [POS_W-1:0]       pos_right_d;
   logic [SCORE_W-1:0]     left_score_d;
   logic [SCORE_W-1:0]     right_score_d;

   always_comb begin
      pull_left        = leftPress & ~rightPress;
      pull_right       = rightPress & ~leftPress;
      left_wins_round  = pull_left  && (pos_q == POS_LEFT);
      right_wins_round = pull_right && (pos_q == POS_RIGHT);
      pos_left_d       = pos_q + POS_W'(1);
      pos_right_d      = pos_q - POS_W'(1);
      left_score_d     = left_score_q + SCORE_W'(1);
      right_score_d    = right_score_q + SCORE_W'(1);
   end

   // --------------------------------------------------------------------------
   // Controller: one clocked process owns every register so that all outputs
   // are registered and change on the edge that samples the press.
   // --------------------------------------------------------------------------
   // NOTE: reset is synchronous -- it is only an ordinary input sampled at the
   // clock edge, so it must not appear in the sensitivity list.
   always_ff @(posedge clk) begin
      // NOTE: every register here is assigned with <= so that all of them see
      // the pre-edge values of each other regardless of statement order.
      round_win_q <= 1'b0;

      if (!reset || newMatch) begin
         // newMatch behaves exactly like reset, and also cancels any pause.
         state_q             <= ST_PLAY;
         pos_q               <= POS_CENTER;
         hold_q              <= '0;
         lights_q            <= LIGHT_CTR;
         left_score_q        <= '0;
         right_score_q       <= '0;
         round_winner_left_q <= 1'b0;
         match_over_q        <= 1'b0;
         match_winner_left_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (left_wins_round) begin
                  lights_q            <= '0;
                  pos_q               <= POS_CENTER;
                  left_score_q        <= left_score_d;
                  round_win_q         <= 1'b1;
                  round_winner_left_q <= 1'b1;
                  if (left_score_d == SCORE_WIN) begin
                     state_q             <= ST_MATCH_OVER;
                     match_over_q        <= 1'b1;
                     match_winner_left_q <= 1'b1;
                  end else begin
                     state_q <= ST_ROUND_END;
                     hold_q  <= HOLD_LOAD;
                  end
               end else if (right_wins_round) begin
                  lights_q            <= '0;
                  pos_q               <= POS_CENTER;
                  right_score_q       <= right_score_d;
                  round_win_q         <= 1'b1;
                  round_winner_left_q <= 1'b0;
                  if (right_score_d == SCORE_WIN) begin
                     state_q             <= ST_MATCH_OVER;
                     match_over_q        <= 1'b1;
                     match_winner_left_q <= 1'b0;
                  end else begin
                     state_q <= ST_ROUND_END;
                     hold_q  <= HOLD_LOAD;
                  end
               end else if (pull_left) begin
                  pos_q    <= pos_left_d;
                  lights_q <= NUM_LIGHTS'(1) << pos_left_d;
               end else if (pull_right) begin
                  pos_q    <= pos_right_d;
                  lights_q <= NUM_LIGHTS'(1) << pos_right_d;
               end
            end

            ST_ROUND_END: begin
               // Field stays dark and presses are ignored. A win at edge k
               // loads HOLD_CYCLES-1, so the counter reads zero at edge
               // k+HOLD_CYCLES, which is when the centre light returns.
               if (hold_q == '0) begin
                  state_q  <= ST_PLAY;
                  pos_q    <= POS_CENTER;
                  lights_q <= LIGHT_CTR;
               end else begin
                  hold_q <= hold_q - CNT_W'(1);
               end
            end

            ST_MATCH_OVER: begin
               // Terminal until reset or newMatch; everything stays frozen.
               lights_q <= '0;
            end

            default: begin
               state_q  <= ST_PLAY;
               pos_q    <= POS_CENTER;
               lights_q <= LIGHT_CTR;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign lights          = lights_q;
   assign leftScore       = left_score_q;
   assign rightScore      = right_score_q;
   assign roundWin        = round_win_q;
   assign roundWinnerLeft = round_winner_left_q;
   assign matchOver       = match_over_q;
   assign matchWinnerLeft = match_winner_left_q;

   // --------------------------------------------------------------------------
   // Design invariants
   // --------------------------------------------------------------------------
`ifndef SYNTHESIS
   a_round_win_pulse : assert property (
      @(posedge clk) disable iff (!reset) round_win_q |=> !round_win_q
   );
   a_score_bound : assert property (
      @(posedge clk) disable iff (!reset)
         (left_score_q <= SCORE_WIN) && (right_score_q <= SCORE_WIN)
   );
   a_dark_when_idle : assert property (
      @(posedge clk) disable iff (!reset)
         (state_q != ST_PLAY) |-> (lights_q == '0)
   );
`endif

endmodule
